shader_program_scheduler: RTL and testbench
===========================================

Name: shader_program_scheduler

Overview:
- Double-buffered staging and upload controller for the shader instruction memory.
- Collects instruction bytes from the SPI receiver into one of two NUM_INSTR-deep banks. Once a bank holds a complete program, it uploads that program into the shader memory, but only during vertical blanking, so a frame never runs a half-written program.
- Sits between spi_receiver and shader_memory, and owns the memory's load/shift control during uploads.

Parameters:
- NUM_INSTR, 10, instructions per program; bank depth and upload length.
- INSTR_W, 8, instruction width in bits.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- wr_valid_i  in  1  instruction byte valid, from SPI receiver
- wr_ready_o  out  1  byte accepted when wr_valid_i && wr_ready_o at a clock edge
- wr_instr_i  in  INSTR_W  instruction byte
- restart_i  in  1  discard the partially collected program (SPI CS deasserted)
- vblank_i  in  1  vertical blanking active, from vertical timing
- mem_instr_o  out  INSTR_W  instruction to shader memory
- mem_load_o  out  1  load mem_instr_o into memory tail
- mem_shift_o  out  1  shift memory chain
- busy_o  out  1  upload in progress
- pending_o  out  1  complete program waiting for upload
- loaded_o  out  1  one-cycle pulse after the last instruction of an upload
- dropped_o  out  1  one-cycle pulse when a pending program is superseded

Behaviour:
- Reset (rst_i high at an edge): state IDLE; fill_bank=0, wr_idx=0, pending=0, pend_bank=0, load_idx=0. All outputs 0 except wr_ready_o=1. Reset mid-upload aborts immediately; shader memory contents are then undefined, and upstream must resend.
- Storage: bank[2][NUM_INSTR] of INSTR_W. wr_idx and load_idx are $clog2(NUM_INSTR) bits wide.
- Write:
  - On accept: bank[fill_bank][wr_idx] <= wr_instr_i.
  - If wr_idx==NUM_INSTR-1, completion occurs: wr_idx<=0, pend_bank<=fill_bank, pending<=1, fill_bank<=~fill_bank.
  - Otherwise wr_idx<=wr_idx+1.
- Supersede: completion while pending=1 and no upload starts that cycle: the new bank replaces the pending one and dropped_o pulses the next cycle. The old pending bank becomes the fill bank.
- restart_i: wr_idx<=0, fill_bank unchanged. A byte accepted in the same cycle is discarded. restart_i has no effect on a pending program or an upload.
- wr_ready_o = !(state==LOAD && fill_bank==load_bank). It stalls writes into the bank being read; it is combinational from registered state.
- IDLE -> LOAD when pending && vblank_i: load_bank<=pend_bank, load_idx<=0, pending<=0. If a completion occurs in the same cycle, pending stays 1 with the new bank, and no drop pulse occurs.
- LOAD:
  - Lasts exactly NUM_INSTR cycles; mem_load_o=mem_shift_o=busy_o=1 throughout.
  - mem_instr_o=bank[load_bank][k] in cycle k, k=0..NUM_INSTR-1 (write order preserved).
  - Outputs are registered: the first instruction appears in the cycle after the start condition.
  - After cycle NUM_INSTR-1: state IDLE, and loaded_o pulses in the next cycle.
  - vblank_i deasserting during LOAD does not abort the upload (blanking is always much longer than NUM_INSTR cycles).
- A new upload cannot start in the same cycle loaded_o pulses; the earliest restart is the following cycle if pending && vblank_i.
- No upload ever starts while vblank_i=0. A program that completes during active video waits for the next vblank.
- mem_instr_o is 0 in IDLE.

Test Plan:
- Reset, write bytes 0x01..0x0A with vblank_i=0 -> pending_o=1, no mem_load_o. Raise vblank_i -> 1 cycle later 10 cycles of mem_load_o, instr 0x01..0x0A in order, then loaded_o pulse; pending_o=0.
- Write 5 bytes, pulse restart_i, write 0x10..0x19, upload -> memory receives 0x10..0x19 only.
- Two complete programs (A: 0xA0.., B: 0xB0..) before vblank -> dropped_o pulses once; upload delivers B.
- Start upload of bank0 and immediately stream the next program: bank1 fills without stall; the first byte for bank0 while still LOAD sees wr_ready_o=0 until loaded_o; no byte lost.
- Program completes in the exact cycle the upload of the previous program starts -> no dropped_o; pending_o stays 1; second upload follows at the next vblank opportunity after loaded_o.
- rst_i asserted at load cycle 4 -> next cycle all mem_* outputs 0, busy_o=0, pending_o=0, wr_ready_o=1.

Source files
------------

// File: rtl/shader_program_scheduler.sv
// shader_program_scheduler: double-buffered program staging with vblank-gated upload into shader memory
module shader_program_scheduler #(
  parameter int NUM_INSTR = 10,
  parameter int INSTR_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [INSTR_W-1:0] wr_instr_i,
  input  logic               restart_i,
  input  logic               vblank_i,
  output logic [INSTR_W-1:0] mem_instr_o,
  output logic               mem_load_o,
  output logic               mem_shift_o,
  output logic               busy_o,
  output logic               pending_o,
  output logic               loaded_o,
  output logic               dropped_o
);
  localparam int IW = $clog2(NUM_INSTR);
  localparam logic [IW-1:0] LAST = IW'(NUM_INSTR - 1);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state_q, state_d;
  logic [INSTR_W-1:0] bank_q [2][NUM_INSTR];
  logic [IW-1:0] wr_idx_q, wr_idx_d, load_idx_q, load_idx_d;
  logic fill_bank_q, fill_bank_d, pend_bank_q, pend_bank_d, load_bank_q, load_bank_d;
  logic pending_q, pending_d, loaded_q, loaded_d, dropped_q, dropped_d;
  logic accept, complete, start, last;
  always_comb begin
    wr_ready_o  = !(state_q == LOAD && fill_bank_q == load_bank_q);
    accept      = wr_valid_i && wr_ready_o && !restart_i;
    complete    = accept && wr_idx_q == LAST;
    // the cycle showing loaded_o may not launch the next upload
    start       = state_q == IDLE && !loaded_q && pending_q && vblank_i;
    last        = state_q == LOAD && load_idx_q == LAST;
    state_d     = start ? LOAD : last ? IDLE : state_q;
    wr_idx_d    = (restart_i || complete) ? '0 : accept ? wr_idx_q + IW'(1) : wr_idx_q;
    fill_bank_d = complete ? ~fill_bank_q : fill_bank_q;
    pend_bank_d = complete ? fill_bank_q : pend_bank_q;
    pending_d   = complete || (pending_q && !start);
    load_bank_d = start ? pend_bank_q : load_bank_q;
    load_idx_d  = (start || last) ? '0 : state_q == LOAD ? load_idx_q + IW'(1) : load_idx_q;
    loaded_d    = last;
    dropped_d   = complete && pending_q && !start;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      load_idx_q  <= '0;
      fill_bank_q <= 1'b0;
      pend_bank_q <= 1'b0;
      load_bank_q <= 1'b0;
      pending_q   <= 1'b0;
      loaded_q    <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      load_idx_q  <= load_idx_d;
      fill_bank_q <= fill_bank_d;
      pend_bank_q <= pend_bank_d;
      load_bank_q <= load_bank_d;
      pending_q   <= pending_d;
      loaded_q    <= loaded_d;
      dropped_q   <= dropped_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept) bank_q[fill_bank_q][wr_idx_q] <= wr_instr_i;
  end
  assign busy_o      = state_q == LOAD;
  assign mem_load_o  = busy_o;
  assign mem_shift_o = busy_o;
  assign mem_instr_o = busy_o ? bank_q[load_bank_q][load_idx_q] : '0;
  assign pending_o   = pending_q;
  assign loaded_o    = loaded_q;
  assign dropped_o   = dropped_q;
endmodule

// File: tb/tb_shader_program_scheduler.sv
// tb_shader_program_scheduler: scoreboard bench for the shader program scheduler
module tb_shader_program_scheduler;
  logic clk_i = 0, rst_i = 1, wr_valid_i = 0, restart_i = 0, vblank_i = 0;
  logic [7:0] wr_instr_i = 0, mem_instr_o;
  logic wr_ready_o, mem_load_o, mem_shift_o, busy_o, pending_o, loaded_o, dropped_o;
  int checks = 0, failures = 0, loaded_cnt = 0, dropped_cnt = 0, load_cnt = 0;
  int s, sum, l0, d0, c0;
  logic [7:0] exp_q[$];

  shader_program_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_instr_i(wr_instr_i), .restart_i(restart_i), .vblank_i(vblank_i),
    .mem_instr_o(mem_instr_o), .mem_load_o(mem_load_o), .mem_shift_o(mem_shift_o),
    .busy_o(busy_o), .pending_o(pending_o), .loaded_o(loaded_o), .dropped_o(dropped_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (loaded_o) loaded_cnt <= loaded_cnt + 1;
    if (dropped_o) dropped_cnt <= dropped_cnt + 1;
    if (mem_load_o) begin
      load_cnt <= load_cnt + 1;
      check("shift", mem_shift_o, 1);
      check("busy", busy_o, 1);
      if (exp_q.size() == 0) check("unexp_load", mem_load_o, 0);
      else check("instr", mem_instr_o, exp_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, output int stalls);
    logic rdy;
    stalls = 0;
    wr_valid_i = 1;
    wr_instr_i = b;
    while (1) begin
      @(negedge clk_i);
      rdy = wr_ready_o;
      @(posedge clk_i);
      #1;
      if (rdy) break;
      stalls++;
      if (stalls > 50) begin
        check("send_timeout", stalls, 0);
        break;
      end
    end
    wr_valid_i = 0;
  endtask

  task automatic send_prog(input logic [7:0] base, input int n);
    int st;
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), st);
  endtask

  task automatic push_prog(input logic [7:0] base);
    for (int i = 0; i < 10; i++) exp_q.push_back(base + 8'(i));
  endtask

  task automatic wait_loaded;
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!loaded_o && n < 200);
    check("loaded_seen", loaded_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", wr_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_pending", pending_o, 0);
    check("rst_load", mem_load_o, 0);
    check("rst_instr", mem_instr_o, 0);
    check("rst_loaded", loaded_o, 0);
    check("rst_dropped", dropped_o, 0);
    @(posedge clk_i); #1 rst_i = 0;
    // basic program held off until vblank
    c0 = load_cnt;
    send_prog(8'h01, 10);
    push_prog(8'h01);
    repeat (3) @(negedge clk_i);
    check("t1_pending", pending_o, 1);
    check("t1_no_load", load_cnt - c0, 0);
    @(posedge clk_i); #1 vblank_i = 1;
    @(negedge clk_i);
    check("t1_pre_start", mem_load_o, 0);
    @(negedge clk_i);
    check("t1_first_load", mem_load_o, 1);
    wait_loaded;
    check("t1_pending_clr", pending_o, 0);
    @(negedge clk_i);
    check("t1_len", load_cnt - c0, 10);
    check("t1_idle_instr", mem_instr_o, 0);
    check("t1_empty", exp_q.size(), 0);
    @(posedge clk_i); #1 vblank_i = 0;
    // partial program discarded by restart, including a byte in the restart cycle
    send_prog(8'h55, 5);
    restart_i = 1;
    send_byte(8'hEE, s);
    restart_i = 0;
    send_prog(8'h10, 10);
    push_prog(8'h10);
    vblank_i = 1;
    wait_loaded;
    @(posedge clk_i); #1 vblank_i = 0;
    check("t2_empty", exp_q.size(), 0);
    // two programs before vblank: the newer one wins
    d0 = dropped_cnt;
    send_prog(8'hA0, 10);
    send_prog(8'hB0, 10);
    push_prog(8'hB0);
    repeat (2) @(negedge clk_i);
    check("t3_dropped", dropped_cnt - d0, 1);
    vblank_i = 1;
    wait_loaded;
    @(posedge clk_i); #1 vblank_i = 0;
    check("t3_empty", exp_q.size(), 0);
    // stream the next program while the previous one uploads
    d0 = dropped_cnt;
    send_prog(8'hC0, 10);
    push_prog(8'hC0);
    vblank_i = 1;
    sum = 0;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'hD0 + 8'(i), s);
      sum += s;
    end
    push_prog(8'hD0);
    check("t4_no_stall", sum, 0);
    l0 = loaded_cnt;
    send_byte(8'hE0, s);
    check("t4_stalled", s > 0, 1);
    check("t4_after_loaded", loaded_cnt - l0, 1);
    restart_i = 1;
    @(posedge clk_i); #1 restart_i = 0;
    wait_loaded;
    @(posedge clk_i); #1 vblank_i = 0;
    check("t4_empty", exp_q.size(), 0);
    check("t4_no_drop", dropped_cnt - d0, 0);
    // completion in the same cycle an upload starts
    d0 = dropped_cnt;
    send_prog(8'hF0, 10);
    push_prog(8'hF0);
    send_prog(8'h20, 9);
    vblank_i = 1;
    send_byte(8'h29, s);
    push_prog(8'h20);
    @(negedge clk_i);
    check("t5_pending", pending_o, 1);
    check("t5_busy", busy_o, 1);
    wait_loaded;
    @(negedge clk_i);
    check("t5_gap", mem_load_o, 0);
    @(negedge clk_i);
    check("t5_restart", mem_load_o, 1);
    wait_loaded;
    @(posedge clk_i); #1 vblank_i = 0;
    check("t5_empty", exp_q.size(), 0);
    check("t5_no_drop", dropped_cnt - d0, 0);
    // reset in the middle of an upload
    send_prog(8'h30, 10);
    push_prog(8'h30);
    vblank_i = 1;
    do @(negedge clk_i); while (!mem_load_o);
    repeat (4) @(posedge clk_i);
    #1 rst_i = 1;
    @(posedge clk_i); #1 rst_i = 0;
    vblank_i = 0;
    check("t6_left", exp_q.size(), 5);
    exp_q.delete();
    l0 = loaded_cnt;
    @(negedge clk_i);
    check("t6_load", mem_load_o, 0);
    check("t6_shift", mem_shift_o, 0);
    check("t6_instr", mem_instr_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_pending", pending_o, 0);
    check("t6_ready", wr_ready_o, 1);
    repeat (12) @(negedge clk_i);
    check("t6_no_loaded", loaded_cnt - l0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
